// File: rtl/conv1_frame_feeder_if.sv
// Shared-address BRAM read port plus the CONV1 sample stream, grouped for conv1_frame_feeder.
// master = feeder side, slave = BRAM/CONV1 side.
interface conv1_frame_feeder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_i;
  logic [DATA_W-1:0] mem_q;

  logic [DATA_W-1:0] dout_i;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (
    output mem_en, mem_addr,
    input  mem_i, mem_q,
    output dout_i, dout_q, dout_valid, dout_last,
    input  dout_ready
  );

  modport slave (
    input  mem_en, mem_addr,
    output mem_i, mem_q,
    input  dout_i, dout_q, dout_valid, dout_last,
    output dout_ready
  );
endinterface

// File: rtl/conv1_frame_feeder.sv
// Reads one frame of I/Q samples from the CONV1 input BRAMs (1-cycle latency) into CONV1's stream input.
// Optional: define CONV1_FEEDER_AUTO_RESTART_EN to stream frames back to back after one start.
module conv1_frame_feeder #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 7,
  parameter int FRAME_LEN = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  conv1_frame_feeder_if.master bus
);
  localparam int                CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] i;
    logic [DATA_W-1:0] q;
    logic              last;
  } entry_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              inflight_q, inflight_last_q;

  entry_t            buf_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        buf_cnt_q, buf_cnt_d;

  entry_t            head;
  logic              push, pop, space_ok, can_read, mem_en, read_last;
  logic [CNT_W-1:0]  rd_idx;

  assign head = buf_q[rd_ptr_q];
  assign push = inflight_q;
  assign pop  = (buf_cnt_q != 2'd0) && bus.dout_ready;

  // Occupancy after the in-flight read lands; a new read only fits if it stays below 2.
  assign space_ok = ({1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;

`ifdef CONV1_FEEDER_AUTO_RESTART_EN
  assign can_read = (state_q == FETCH) || (state_q == DRAIN);
`else
  assign can_read = (state_q == FETCH);
`endif

  assign mem_en    = can_read && space_ok;
  // A read issued from DRAIN is the first read of the next frame.
  assign rd_idx    = (state_q == DRAIN) ? '0 : rd_cnt_q;
  assign read_last = (rd_idx == LAST_IDX);

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    addr_d   = addr_q;
    done_d   = pop && head.last;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          rd_cnt_d = '0;
          addr_d   = '0;
        end
      end
      FETCH, DRAIN: begin
        if (mem_en) begin
          rd_cnt_d = read_last ? '0 : rd_idx + CNT_W'(1);
          addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
          state_d  = read_last ? DRAIN : FETCH;
        end
`ifndef CONV1_FEEDER_AUTO_RESTART_EN
        if ((state_q == DRAIN) && done_d) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_cnt_d = buf_cnt_q;
    case ({push, pop})
      2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
      2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
      default: buf_cnt_d = buf_cnt_q;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rd_cnt_q        <= '0;
      addr_q          <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_cnt_q        <= rd_cnt_d;
      addr_q          <= addr_d;
      done_q          <= done_d;
      inflight_q      <= mem_en;
      inflight_last_q <= mem_en && read_last;
    end
  end

  // NOTE: buffer storage is reset as well so dout_i/dout_q read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        buf_q[k] <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      buf_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= {bus.mem_i, bus.mem_q, inflight_last_q};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      buf_cnt_q <= buf_cnt_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign bus.mem_en     = mem_en;
  assign bus.mem_addr   = addr_q;
  assign bus.dout_i     = head.i;
  assign bus.dout_q     = head.q;
  assign bus.dout_last  = head.last;
  assign bus.dout_valid = (buf_cnt_q != 2'd0);
endmodule

// File: tb/tb_conv1_frame_feeder.sv
// Scoreboard bench for conv1_frame_feeder: stimulus pushes expected samples, a negedge monitor checks them.
// A second instance with FRAME_LEN=1 covers the single-sample frame.
module tb_conv1_frame_feeder;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 7;
  localparam int FRAME_LEN = 128;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic busy, done, busy1, done1;

  conv1_frame_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  conv1_frame_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  conv1_frame_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  conv1_frame_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .bus(bus1)
  );

  always #5 clk = ~clk;

  // BRAM models: I = address, Q = address + 0x100, one cycle after the enable.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_i <= 16'(bus.mem_addr);
      bus.mem_q <= 16'(bus.mem_addr) + 16'h0100;
    end
    if (bus1.mem_en) begin
      bus1.mem_i <= 16'(bus1.mem_addr);
      bus1.mem_q <= 16'(bus1.mem_addr) + 16'h0100;
    end
  end

  int   rdy_mode  = 0;
  logic rdy_fixed = 1'b1;

  initial begin
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.dout_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   n_acc    = 0;
  int   cyc      = 0;
  int   first_acc_cyc = 0;
  int   last_acc_cyc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < FRAME_LEN; k++) begin
      exp_q.push_back({16'(k), 16'(k) + 16'h0100, (k == FRAME_LEN - 1)});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(n_done >= target), 1);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares every accepted sample against the scoreboard and checks stalls and done timing.
  logic prev_stall    = 1'b0;
  logic prev_last_acc = 1'b0;
  exp_t prev_out      = '0;

  always @(negedge clk) begin
    exp_t got, want;
    if (!rst_n) begin
      prev_stall    = 1'b0;
      prev_last_acc = 1'b0;
    end else begin
      check("done_timing", done, prev_last_acc);
`ifndef CONV1_FEEDER_AUTO_RESTART_EN
      if (prev_last_acc) check("busy_falls_with_done", busy, 0);
`endif
      if (done) n_done++;
      got = {bus.dout_i, bus.dout_q, bus.dout_last};
      if (prev_stall) begin
        check("stall_valid_held", bus.dout_valid, 1);
        check("stall_data_held", 64'(got), 64'(prev_out));
      end
      prev_last_acc = 1'b0;
      prev_stall    = bus.dout_valid && !bus.dout_ready;
      prev_out      = got;
      if (bus.dout_valid && bus.dout_ready) begin
        check("sample_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check("sample", 64'(got), 64'(want));
          prev_last_acc = want.last;
        end
        if (n_acc == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_en"}, bus.mem_en, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_dout_valid"}, bus.dout_valid, 0);
    check({tag, "_dout_last"}, bus.dout_last, 0);
    check({tag, "_dout_i"}, bus.dout_i, 0);
    check({tag, "_dout_q"}, bus.dout_q, 0);
  endtask

  task automatic test_free();
    int d0, lat;
    rdy_fixed = 1'b1;
    repeat (2) @(negedge clk);
    n_acc = 0;
    d0 = n_done;
    push_frame();
    pulse_start();
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!bus.dout_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("first_valid_latency", lat, 3);
    wait_done(d0 + 1, 400);
    check("free_throughput", last_acc_cyc - first_acc_cyc, FRAME_LEN - 1);
    check("free_addr_back_to_0", bus.mem_addr, 0);
    check("free_idle", busy, 0);
    check("free_acc_count", n_acc, FRAME_LEN);
    check("free_queue_drained", exp_q.size(), 0);
  endtask

  task automatic test_stall();
    int d0, en_cnt;
    rdy_fixed = 1'b0;
    repeat (2) @(negedge clk);
    n_acc = 0;
    d0 = n_done;
    push_frame();
    pulse_start();
    en_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
    end
    check("stall_reads_issued", en_cnt, 2);
    check("stall_mem_en_low", bus.mem_en, 0);
    check("stall_valid_up", bus.dout_valid, 1);
    rdy_mode = 1;
    wait_done(d0 + 1, 2000);
    rdy_mode  = 0;
    rdy_fixed = 1'b1;
    check("rand_acc_count", n_acc, FRAME_LEN);
    check("rand_queue_drained", exp_q.size(), 0);
  endtask

  task automatic test_start_busy();
    int d0, k;
    rdy_fixed = 1'b1;
    repeat (2) @(negedge clk);
    n_acc = 0;
    d0 = n_done;
    push_frame();
    pulse_start();
    k = 0;
    while (n_acc < 50 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("reached_sample_50", 64'(n_acc >= 50), 1);
    pulse_start();
    wait_done(d0 + 1, 400);
    repeat (20) @(negedge clk);
    check("busy_start_single_done", n_done, d0 + 1);
    check("busy_start_acc_count", n_acc, FRAME_LEN);
    check("busy_start_idle", busy, 0);
  endtask

  task automatic test_reset_mid();
    int d0, k;
    rdy_fixed = 1'b1;
    n_acc = 0;
    d0 = n_done;
    push_frame();
    pulse_start();
    k = 0;
    while (n_acc < 60 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("reached_sample_60", 64'(n_acc >= 60), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", n_done, d0);
    check("midrst_idle", busy, 0);
    n_acc = 0;
    push_frame();
    pulse_start();
    wait_done(d0 + 1, 400);
    check("restart_acc_count", n_acc, FRAME_LEN);
    check("restart_queue_drained", exp_q.size(), 0);
  endtask

  task automatic test_auto();
    int d0, k, drops;
    rdy_fixed = 1'b1;
    repeat (2) @(negedge clk);
    n_acc = 0;
    d0 = n_done;
    repeat (4) push_frame();
    pulse_start();
    k = 0;
    drops = 0;
    while (n_done < d0 + 3 && k < 1000) begin
      @(negedge clk);
      if (!busy) drops++;
      k++;
    end
    check("auto_three_dones", 64'(n_done >= d0 + 3), 1);
    check("auto_busy_never_drops", drops, 0);
    check("auto_no_gap", last_acc_cyc - first_acc_cyc, n_acc - 1);
    check("auto_enough_samples", 64'(n_acc >= 3 * FRAME_LEN), 1);
  endtask

  task automatic test_len1();
    int k;
    @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    check("len1_busy", busy1, 1);
    k = 0;
    while (!bus1.dout_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("len1_latency", k, 3);
    check("len1_dout_i", bus1.dout_i, 16'h0000);
    check("len1_dout_q", bus1.dout_q, 16'h0100);
    check("len1_last", bus1.dout_last, 1);
    @(negedge clk);
    check("len1_done", done1, 1);
`ifndef CONV1_FEEDER_AUTO_RESTART_EN
    check("len1_idle", busy1, 0);
    @(negedge clk);
    check("len1_done_pulse", done1, 0);
`endif
  endtask

  initial begin
    bus1.dout_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    #2 rst_n = 1'b1;
`ifdef CONV1_FEEDER_AUTO_RESTART_EN
    test_auto();
`else
    test_free();
    test_stall();
    test_start_busy();
    test_reset_mid();
`endif
    test_len1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
